// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU opcode constants and execute-unit FSM state type.
// Both packages must be compiled before alu_exec_unit and serial_shifter.

package alu_encoding;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_AND    = 4'h2;
  localparam logic [3:0] ALU_OR     = 4'h3;
  localparam logic [3:0] ALU_XOR    = 4'h4;
  localparam logic [3:0] ALU_SLT    = 4'h5;
  localparam logic [3:0] ALU_SLL    = 4'h6;
  localparam logic [3:0] ALU_SRL    = 4'h7;
  localparam logic [3:0] ALU_SRA    = 4'h8;
  localparam logic [3:0] ALU_PASS_B = 4'h9;

  function automatic logic is_shift_op(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

package cpu_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_exec_state_t;

endpackage

// File: rtl/alu_exec_unit_serial_shifter.sv
// Iterative shifter: moves SHIFT_STEP bits per cycle until the loaded amount is used up.
// done/data_out present the value that will be held after the current cycle's final step.

module serial_shifter
  import alu_encoding::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            load,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] data,
  input  logic [4:0]      amount,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] data_out
);

  logic [XLEN-1:0] data_q, data_nxt;
  logic [4:0]      cnt_q, cnt_nxt;
  logic [3:0]      op_q;

  // Unrolled single-bit steps; each only fires while count remains, so k = min(step, count).
  always_comb begin
    data_nxt = data_q;
    cnt_nxt  = cnt_q;
    for (int unsigned i = 0; i < SHIFT_STEP; i++) begin
      if (cnt_nxt != 5'd0) begin
        case (op_q)
          ALU_SLL: data_nxt = {data_nxt[XLEN-2:0], 1'b0};
          ALU_SRL: data_nxt = {1'b0, data_nxt[XLEN-1:1]};
          default: data_nxt = {data_nxt[XLEN-1], data_nxt[XLEN-1:1]};
        endcase
        cnt_nxt = cnt_nxt - 5'd1;
      end
    end
  end

  assign busy     = (cnt_q != 5'd0);
  assign done     = busy && (cnt_nxt == 5'd0);
  assign data_out = data_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      op_q   <= '0;
    end else if (kill) begin
      cnt_q <= '0;
    end else if (load) begin
      data_q <= data;
      cnt_q  <= amount;
      op_q   <= op;
    end else if (busy) begin
      data_q <= data_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes, registered result and zero flag.
// Define ALU_EXEC_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.

module alu_exec_unit
  import alu_encoding::*;
  import cpu_types::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  alu_exec_state_t state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            sh_load, sh_busy, sh_done;
  logic [XLEN-1:0] sh_out;

  function automatic logic [XLEN-1:0] alu_compute(input logic [3:0]      ctrl,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (ctrl)
      ALU_ADD:    r = a + b;
      ALU_SUB:    r = a - b;
      ALU_AND:    r = a & b;
      ALU_OR:     r = a | b;
      ALU_XOR:    r = a ^ b;
      ALU_SLT:    r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_PASS_B: r = b;
`ifdef ALU_EXEC_FAST_SHIFT_EN
      ALU_SLL:    r = a << b[4:0];
      ALU_SRL:    r = a >> b[4:0];
      ALU_SRA:    r = XLEN'($signed(a) >>> b[4:0]);
`else
      // Only zero-amount shifts take this path; nonzero amounts go to the serial shifter.
      ALU_SLL, ALU_SRL, ALU_SRA: r = a;
`endif
      default:    r = '0;
    endcase
    return r;
  endfunction

`ifdef ALU_EXEC_FAST_SHIFT_EN
  localparam bit FastShift = 1'b1;

  assign sh_busy = 1'b0;
  assign sh_done = 1'b0;
  assign sh_out  = '0;
`else
  localparam bit FastShift = 1'b0;

  serial_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_serial_shifter (
    .clk      (clk),
    .rst      (rst),
    .kill     (kill),
    .load     (sh_load),
    .op       (alu_ctrl),
    .data     (op_a),
    .amount   (op_b[4:0]),
    .busy     (sh_busy),
    .done     (sh_done),
    .data_out (sh_out)
  );
`endif

  assign in_ready  = (state_q == IDLE) && !kill && !sh_busy;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    sh_load  = 1'b0;
    if (kill) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (!FastShift && is_shift_op(alu_ctrl) && (op_b[4:0] != 5'd0)) begin
              sh_load = 1'b1;
              state_d = SHIFT;
            end else begin
              result_d = alu_compute(alu_ctrl, op_a, op_b);
              zero_d   = (result_d == '0);
              state_d  = DONE;
            end
          end
        end
        SHIFT: begin
          if (sh_done) begin
            result_d = sh_out;
            zero_d   = (sh_out == '0);
            state_d  = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops push expectations, a monitor checks outputs.
// A second instance with SHIFT_STEP=4 checks multi-bit stepping latency and results.

module tb_alu_exec_unit;
  import alu_encoding::*;

  localparam int Step = 1;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, kill, in_valid, in_ready, out_valid, out_ready, zero;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b, result;
  logic        in_valid4, in_ready4, out_valid4, zero4;
  logic [31:0] result4;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(Step)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .kill      (kill),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .kill      (kill),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .result    (result4),
    .zero      (zero4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input bit sh, input int n, input int step);
`ifdef ALU_EXEC_FAST_SHIFT_EN
    return 1;
`else
    if (!sh || n == 0) return 1;
    return 1 + (n + step - 1) / step;
`endif
  endfunction

  // Monitor: every handshake on the result side pops one expectation.
  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected output: got %h want none", result);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check({n, " result"}, result, e.r);
        check({n, " zero"}, {31'b0, zero}, {31'b0, e.z});
      end
    end
  end

  // Called at posedge+1; returns at the negedge where out_valid first rises.
  task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input int el);
    int   lat;
    bit   ready_bad;
    exp_t e;
    e.r = er;
    e.z = (er == 32'd0);
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk);
    check({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = 32'hdeadbeef; op_b = 32'h5a5a5a5f; alu_ctrl = ALU_XOR;
    lat = 0;
    ready_bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) ready_bad = 1'b1;
    end while (!out_valid && lat < 200);
    check({name, " latency"}, 32'(lat), 32'(el));
    check({name, " in_ready while busy"}, {31'b0, ready_bad}, 32'd0);
  endtask

  task automatic run_op4(input string name, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input int el);
    int lat;
    alu_ctrl = c; op_a = a; op_b = b; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0; op_a = 32'h12345678;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid4 && lat < 200);
    check({name, " step4 latency"}, 32'(lat), 32'(el));
    check({name, " step4 result"}, result4, er);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    rst = 1'b1; kill = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
    alu_ctrl = ALU_ADD; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset zero", {31'b0, zero}, 32'd0);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    run_op("add", ALU_ADD, 32'd5, 32'd7, 32'd12, 1);                        @(posedge clk); #1;
    run_op("sub", ALU_SUB, 32'd3, 32'd3, 32'd0, 1);                         @(posedge clk); #1;
    run_op("slt", ALU_SLT, 32'hffffffff, 32'd1, 32'd1, 1);                  @(posedge clk); #1;
    run_op("slt_ge", ALU_SLT, 32'd1, 32'hffffffff, 32'd0, 1);               @(posedge clk); #1;
    run_op("and", ALU_AND, 32'h0000f0f0, 32'h0000ff00, 32'h0000f000, 1);    @(posedge clk); #1;
    run_op("or", ALU_OR, 32'h0000f0f0, 32'h0000ff00, 32'h0000fff0, 1);      @(posedge clk); #1;
    run_op("xor", ALU_XOR, 32'h0000f0f0, 32'h0000ff00, 32'h00000ff0, 1);    @(posedge clk); #1;
    run_op("pass_b", ALU_PASS_B, 32'hffffffff, 32'h00001234, 32'h1234, 1);  @(posedge clk); #1;
    run_op("undef", 4'hf, 32'd9, 32'd9, 32'd0, 1);                          @(posedge clk); #1;
    run_op("sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hffffffff, 1);             @(posedge clk); #1;
    run_op("add_wrap", ALU_ADD, 32'hffffffff, 32'd1, 32'd0, 1);             @(posedge clk); #1;
    run_op("sll31", ALU_SLL, 32'd1, 32'd31, 32'h80000000, lat_of(1, 31, Step));
    @(posedge clk); #1;
    run_op("sra4", ALU_SRA, 32'h80000000, 32'd4, 32'hf8000000, lat_of(1, 4, Step));
    @(posedge clk); #1;
    run_op("srl4", ALU_SRL, 32'h80000000, 32'd4, 32'h08000000, lat_of(1, 4, Step));
    @(posedge clk); #1;
    run_op("srl0", ALU_SRL, 32'h80000000, 32'd0, 32'h80000000, 1);          @(posedge clk); #1;
    run_op("sll_hi", ALU_SLL, 32'h00000003, 32'hffffffe1, 32'h00000006, lat_of(1, 1, Step));
    @(posedge clk); #1;

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    run_op("bp_add", ALU_ADD, 32'd2, 32'd3, 32'd5, 1);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("bp out_valid", {31'b0, out_valid}, 32'd1);
      check("bp result", result, 32'd5);
      check("bp in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp release in_ready", {31'b0, in_ready}, 32'd1);
    check("bp release out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Kill mid-shift: SLL by 20, kill during T+5.
    alu_ctrl = ALU_SLL; op_a = 32'd1; op_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 kill = 1'b1;
    @(negedge clk);
    check("kill in_ready low", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1 kill = 1'b0;
    @(negedge clk);
    check("kill idle in_ready", {31'b0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("kill out_valid never", {31'b0, seen}, 32'd0);
    check("kill result retained", result, 32'd5);
    @(posedge clk); #1;
    run_op("add_after_kill", ALU_ADD, 32'd1, 32'd1, 32'd2, 1);              @(posedge clk); #1;

    // Kill coincident with accept discards the request.
    alu_ctrl = ALU_ADD; op_a = 32'd4; op_b = 32'd4; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; kill = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("kill at accept out_valid", {31'b0, seen}, 32'd0);
    check("kill at accept result", result, 32'd2);
    @(posedge clk); #1;

    // Reset mid-shift returns to reset values.
    alu_ctrl = ALU_SLL; op_a = 32'd1; op_b = 32'd10; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid reset out_valid", {31'b0, out_valid}, 32'd0);
    check("mid reset result", result, 32'd0);
    check("mid reset in_ready", {31'b0, in_ready}, 32'd1);
    repeat (15) @(posedge clk);
    #1;

    run_op4("sll31", ALU_SLL, 32'd1, 32'd31, 32'h80000000, lat_of(1, 31, 4));
    run_op4("sra4", ALU_SRA, 32'h80000000, 32'd4, 32'hf8000000, lat_of(1, 4, 4));
    run_op4("srl5", ALU_SRL, 32'h80000000, 32'd5, 32'h04000000, lat_of(1, 5, 4));

    repeat (3) @(posedge clk);
    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit alu_ctrl code from ALU control plus two XLEN operands. It returns a registered result and a zero flag for branch resolution.
- Non-shift ops complete in one cycle.
- Shifts use an area-saving iterative shifter.
- A valid/ready handshake on both sides lets the core stall fetch/decode while a shift is in flight.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
SHIFT_STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
kill  in  1  synchronous abort of any in-flight op (pipeline flush)
in_valid  in  1  operation request
in_ready  out  1  unit can accept a request
alu_ctrl  in  4  operation code from alu_encoding (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS_B)
op_a  in  XLEN  operand A
op_b  in  XLEN  operand B; shift amount is op_b[4:0]
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  XLEN  registered result
zero  out  1  registered (result == 0)

Behaviour:
- States: IDLE, SHIFT, DONE.
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, shift count=0. Reset asserted mid-operation abandons the operation, identical to the reset values.
- in_ready=1 only in IDLE, and never while kill=1.
- Accept occurs when in_valid && in_ready in cycle T.
  - Non-shift op, or shift with op_b[4:0]==0: compute the result, register it, go to DONE. out_valid=1 from T+1.
  - Shift with n=op_b[4:0]>0: load op_a into the shift register, count=n, go to SHIFT.
- SHIFT, each cycle:
  - shift by k=min(SHIFT_STEP,count); count -= k.
  - SLL fills 0. SRL fills 0. SRA fills op_a[31].
  - When the updated count is 0, register the result and go to DONE.
  - out_valid from T+1+ceil(n/SHIFT_STEP).
- DONE: out_valid=1. result and zero stay stable until out_ready=1, then IDLE next cycle. No new accept in the same cycle as the handshake, so the throughput is at most one op per 2 cycles.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^32.
  - SLT is a signed compare; result is 32'h1 or 32'h0.
  - PASS_B gives result=op_b.
  - An undefined alu_ctrl code gives result=0 and zero=1, taking the non-shift path.
- zero is always computed from the value being registered into result.
- kill has priority over everything except rst. In any state: next state IDLE, out_valid=0 next cycle, count cleared, result/zero retain old values. A kill coincident with accept discards the request.
- Operands are captured at accept; input changes afterwards have no effect.

Optional Feature:
Macro ALU_EXEC_FAST_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter. Every op reaches DONE at T+1, SHIFT is unreachable and not synthesized, and SHIFT_STEP is ignored.
- Undefined: iterative SHIFT behaviour as above.
- Functional results are identical in both builds; only latency differs.

Decomposition:
- alu_encoding package: the existing ALU_* 4-bit constants; add an is_shift_op function (SLL/SRL/SRA).
- cpu_types package: typedef enum alu_exec_state_t {IDLE, SHIFT, DONE}.
- Sub-module serial_shifter: holds the shift register and count. Ports: load, op, data, amount, busy, done, data_out. alu_exec_unit owns the FSM, handshake and non-shift datapath.

Test Plan:
- ADD op_a=5, op_b=7, accept at T -> out_valid at T+1, result=12, zero=0.
- SUB op_a=3, op_b=3 -> result=0, zero=1. SLT op_a=0xFFFFFFFF, op_b=1 -> result=1.
- SLL op_a=1, op_b=31, SHIFT_STEP=1 -> in_ready=0 during T+1..T+31, out_valid at T+32, result=0x80000000. With SHIFT_STEP=4 -> out_valid at T+9.
- SRA op_a=0x80000000, op_b=4 -> result=0xF8000000. SRL same operands -> 0x08000000. SRL op_b=0 -> out_valid at T+1, result=0x80000000.
- Backpressure: out_ready=0 for 3 cycles in DONE -> result/out_valid stable and in_ready=0. out_ready=1 -> IDLE and in_ready=1 next cycle.
- kill asserted mid-shift (SLL by 20, kill at T+5) -> IDLE at T+6, out_valid never rises. A following ADD 1+1 completes normally with result=2.
